// File: rtl/adder_pipe.sv
// Carry-chained adder/subtractor, one PIPE_WIDTH slice per stage; operands are skewed in and the result deskewed out.
// Latency N+REG_IN_CAS+REG_OUT_CAS cycles; one operation per cycle, never backpressures.
module adder_pipe #(
    parameter int IN_WIDTH    = 501,
    parameter int STAGE_WIDTH = 32,
    parameter int SUB         = 0,
    parameter int REG_IN_CAS  = 0,
    parameter int REG_OUT_CAS = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] A,
    input  logic [IN_WIDTH-1:0] B,
    input  logic                Cin,
    output logic [IN_WIDTH-1:0] S,
    output logic                Cout,
    output logic                out_valid
);
    localparam int PW   = (STAGE_WIDTH % 2 == 0) ? STAGE_WIDTH : STAGE_WIDTH - 1;
    localparam int N    = (IN_WIDTH + PW - 1) / PW;
    localparam int PADW = N * PW;

    logic [IN_WIDTH-1:0] a_i;
    logic [IN_WIDTH-1:0] b_i;
    logic                cin_i;
    logic                vld_i;

    if (REG_IN_CAS != 0) begin : g_in_reg
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                a_i   <= '0;
                b_i   <= '0;
                cin_i <= 1'b0;
                vld_i <= 1'b0;
            end else begin
                a_i   <= A;
                b_i   <= B;
                cin_i <= Cin;
                vld_i <= in_valid;
            end
        end
    end else begin : g_in_wire
        assign a_i   = A;
        assign b_i   = B;
        assign cin_i = Cin;
        assign vld_i = in_valid;
    end

    // Zero padding of the top slice makes bit IN_WIDTH of the padded result the true carry/borrow.
    logic [PADW-1:0] a_pad;
    logic [PADW-1:0] b_pad;
    assign a_pad = PADW'(a_i);
    assign b_pad = PADW'(b_i);

    logic [N-1:0]    cy;
    logic [PADW-1:0] res_all;

    for (genvar k = 0; k < N; k++) begin : g_slice
        logic [PW-1:0] a_st;
        logic [PW-1:0] b_st;
        logic          cin_st;
        logic [PW:0]   ext;
        logic [PW-1:0] sum_q;
        logic          cy_q;
        logic [PW-1:0] res_dsk;

        if (k == 0) begin : g_noskew
            assign a_st   = a_pad[PW-1:0];
            assign b_st   = b_pad[PW-1:0];
            assign cin_st = cin_i;
        end else begin : g_skew
            logic [PW-1:0] a_d [k];
            logic [PW-1:0] b_d [k];
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < k; i++) begin
                        a_d[i] <= '0;
                        b_d[i] <= '0;
                    end
                end else begin
                    a_d[0] <= a_pad[k*PW +: PW];
                    b_d[0] <= b_pad[k*PW +: PW];
                    for (int i = 1; i < k; i++) begin
                        a_d[i] <= a_d[i-1];
                        b_d[i] <= b_d[i-1];
                    end
                end
            end
            assign a_st   = a_d[k-1];
            assign b_st   = b_d[k-1];
            assign cin_st = cy[k-1];
        end

        // Bit PW of the extended difference is set exactly when the slice goes negative.
        if (SUB != 0) begin : g_sub
            assign ext = {1'b0, a_st} - {1'b0, b_st} - {{PW{1'b0}}, cin_st};
        end else begin : g_add
            assign ext = {1'b0, a_st} + {1'b0, b_st} + {{PW{1'b0}}, cin_st};
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sum_q <= '0;
                cy_q  <= 1'b0;
            end else begin
                sum_q <= ext[PW-1:0];
                cy_q  <= ext[PW];
            end
        end
        assign cy[k] = cy_q;

        if (k == N - 1) begin : g_nodsk
            assign res_dsk = sum_q;
        end else begin : g_dsk
            localparam int D = N - 1 - k;
            logic [PW-1:0] r_d [D];
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < D; i++) r_d[i] <= '0;
                end else begin
                    r_d[0] <= sum_q;
                    for (int i = 1; i < D; i++) r_d[i] <= r_d[i-1];
                end
            end
            assign res_dsk = r_d[D-1];
        end
        assign res_all[k*PW +: PW] = res_dsk;
    end

    logic [N-1:0] vld_sr;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= vld_i;
            for (int i = 1; i < N; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    logic [PADW:0] full;
    assign full = {cy[N-1], res_all};

    if (PADW > IN_WIDTH) begin : g_pad
        logic pad_unused;
        assign pad_unused = ^full[PADW:IN_WIDTH+1];
    end

    if (REG_OUT_CAS != 0) begin : g_out_reg
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                S         <= '0;
                Cout      <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                S         <= full[IN_WIDTH-1:0];
                Cout      <= full[IN_WIDTH];
                out_valid <= vld_sr[N-1];
            end
        end
    end else begin : g_out_wire
        assign S         = full[IN_WIDTH-1:0];
        assign Cout      = full[IN_WIDTH];
        assign out_valid = vld_sr[N-1];
    end
endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench: four adder_pipe variants (add, sub, odd stage width, in/out registers) share one stimulus stream.
module tb_adder_pipe;
    localparam int W  = 501;
    localparam int NI = 4;

    typedef struct {
        logic [W:0] val;
        int         due;
    } exp_t;

    logic         clk;
    logic         resetn;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;

    logic [W-1:0] os [NI];
    logic         oc [NI];
    logic         ov [NI];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   lat [NI] = '{16, 16, 16, 18};
    exp_t q [NI][$];

    adder_pipe #(.IN_WIDTH(W), .STAGE_WIDTH(32), .SUB(0), .REG_IN_CAS(0), .REG_OUT_CAS(0)) u_add (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .A(A), .B(B), .Cin(Cin),
        .S(os[0]), .Cout(oc[0]), .out_valid(ov[0]));
    adder_pipe #(.IN_WIDTH(W), .STAGE_WIDTH(32), .SUB(1), .REG_IN_CAS(0), .REG_OUT_CAS(0)) u_sub (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .A(A), .B(B), .Cin(Cin),
        .S(os[1]), .Cout(oc[1]), .out_valid(ov[1]));
    adder_pipe #(.IN_WIDTH(W), .STAGE_WIDTH(33), .SUB(0), .REG_IN_CAS(0), .REG_OUT_CAS(0)) u_odd (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .A(A), .B(B), .Cin(Cin),
        .S(os[2]), .Cout(oc[2]), .out_valid(ov[2]));
    adder_pipe #(.IN_WIDTH(W), .STAGE_WIDTH(32), .SUB(0), .REG_IN_CAS(1), .REG_OUT_CAS(1)) u_cas (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .A(A), .B(B), .Cin(Cin),
        .S(os[3]), .Cout(oc[3]), .out_valid(ov[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_vec(input string nm, input logic [W:0] got, input logic [W:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, got, req);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", nm, got, req);
        end
    endtask

    // Monitor: every out_valid pops one expectation, which must also be due on this very cycle.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            for (int i = 0; i < NI; i++) begin
                if (ov[i]) begin
                    if (q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stray_valid inst%0d cycle %0d got out_valid=1 required 0", i, cyc);
                    end else begin
                        e = q[i].pop_front();
                        chk_vec($sformatf("inst%0d_result", i), {oc[i], os[i]}, e.val);
                        chk_int($sformatf("inst%0d_arrival_cycle", i), cyc, e.due);
                    end
                end else if (q[i].size() > 0 && q[i][0].due <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_result inst%0d got out_valid=0 at cycle %0d required 1", i, cyc);
                    void'(q[i].pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W:0] ea, input logic [W:0] es);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        A        = a;
        B        = b;
        Cin      = c;
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            e.val = (i == 1) ? es : ea;
            e.due = cyc + lat[i];
            q[i].push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        int left;
        n    = 0;
        left = 1;
        while (left != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            left = q[0].size() + q[1].size() + q[2].size() + q[3].size();
        end
        chk_int(nm, left, 0);
    endtask

    task automatic chk_outputs_zero(input string nm);
        for (int i = 0; i < NI; i++) begin
            chk_vec($sformatf("%s_data_inst%0d", nm, i), {oc[i], os[i]}, '0);
            chk_int($sformatf("%s_valid_inst%0d", nm, i), int'(ov[i]), 0);
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r[W-1:0];
    endfunction

    logic [W-1:0] ra [60];
    logic [W-1:0] rb [60];
    logic [W-1:0] ones;
    logic [W:0]   ea;
    logic [W:0]   es;

    initial begin
        resetn   = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        ones     = {W{1'b1}};
        repeat (3) @(posedge clk);
        #2;
        chk_outputs_zero("reset_state");
        resetn = 1'b1;
        idle(2);

        // Hand-computed directed vectors: {Cout,S} for add and for subtract.
        issue(ones, 501'd1, 1'b0, {1'b1, {W{1'b0}}}, {1'b0, {(W-1){1'b1}}, 1'b0});
        issue(501'd5, 501'd7, 1'b0, 502'd12, {1'b1, {(W-1){1'b1}}, 1'b0});
        issue(501'd7, 501'd5, 1'b0, 502'd12, 502'd2);
        issue(501'h0_FFFF_FFFF, 501'd1, 1'b0, 502'h1_0000_0000, 502'h0_FFFF_FFFE);
        idle(1);
        issue(501'd0, 501'd0, 1'b1, 502'd1, {(W+1){1'b1}});
        idle(1);
        issue(ones, ones, 1'b1, {1'b1, {W{1'b1}}}, {(W+1){1'b1}});
        idle(1);
        drain("drain_directed", 40);

        for (int i = 0; i < 60; i++) begin
            ra[i] = rand_op();
            rb[i] = rand_op();
        end
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 60; i++) begin
                ea = {1'b0, ra[i]} + {1'b0, rb[i]} + (W+1)'(c);
                es = {1'b0, ra[i]} - {1'b0, rb[i]} - (W+1)'(c);
                issue(ra[i], rb[i], c[0], ea, es);
            end
        end
        idle(1);
        drain("drain_random", 40);

        // Reset with five operations in flight: outputs clear at once and nothing stale emerges.
        for (int i = 0; i < 5; i++) issue(ra[i], rb[i], 1'b0, '0, '0);
        idle(1);
        #2;
        resetn = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        for (int i = 0; i < NI; i++) q[i].delete();
        repeat (3) @(posedge clk);
        #3;
        resetn = 1'b1;
        idle(25);
        issue(501'd100, 501'd58, 1'b1, 502'd159, 502'd41);
        idle(1);
        drain("drain_post_reset", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
